parity_frame_accum: RTL and testbench
=====================================

# parity_frame_accum

Multi-channel streaming parity generator that accumulates even or odd parity across a frame of up to MAXLEN words per channel and returns one parity bit per channel with a valid/ready handshake. It sits in the ALU status path after the combinational single-word parity unit. It covers multi-word operands, channel counts beyond two, selectable odd/even sense and backpressure.

## Interface
- WIDTH, 8, bits per channel word
- NCH, 2, number of independent channels
- MAXLEN, 16, maximum beats per frame (≥1); count width CW = $clog2(MAXLEN+1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- E  in  1  enable; low blocks acceptance of new beats
- mode  in  1  0 = even parity, 1 = odd parity; sampled on first beat of frame
- in_valid  in  1  beat offered
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- in_last  in  1  final beat of frame
- out_valid  out  1  frame result available
- out_ready  in  1  consumer takes result
- out_parity  out  NCH  per-channel parity bit
- out_len  out  CW  beats accepted in frame (1..MAXLEN)
- out_trunc  out  1  frame closed at MAXLEN without in_last

## Operation
- States: IDLE (no frame open), ACCUM (frame open), HOLD (result presented).
- in_ready = E && (state != HOLD).
- IDLE, beat accepted: acc[c] <= ^in_data[c]; cnt <= 1; mode latched. Go to HOLD if in_last or MAXLEN==1, else ACCUM.
- ACCUM, beat accepted: acc[c] <= acc[c] ^ (^in_data[c]); cnt <= cnt+1. Go to HOLD if in_last or cnt+1 == MAXLEN.
- Entering HOLD without in_last sets trunc = 1. in_last on beat MAXLEN gives trunc = 0.
- out_parity[c] = acc[c] ^ mode_latched. Data bits plus parity bit then hold an even (mode 0) or odd (mode 1) number of ones.
- HOLD: out_valid = 1, outputs stable. On out_ready go to IDLE, and acc, cnt and trunc clear.
- E low: no beats accepted. An open frame stays open, and a HOLD result stays presented and can still be taken.
- mode changes after the first beat have no effect until the next frame.
- Reset (async, any state): state = IDLE; acc, cnt, trunc, mode_latched = 0; out_valid = 0, out_parity = 0, out_len = 0, out_trunc = 0. In-flight frame is discarded.

## Timing
- out_valid rises the cycle after the closing beat is accepted (latency 1).
- The result handshake takes one cycle. The next frame's first beat is accepted no earlier than the cycle after out_valid && out_ready.
- Peak throughput: one beat per cycle within a frame. A frame of L beats occupies ≥ L+1 cycles.
- All outputs are registered. No combinational path from in_* to out_*.

## Configuration
- PARITY_CHECK_EN defined adds these features:
  - input in_exp [NCH], sampled with the closing beat;
  - output out_err [NCH] = out_parity ^ exp_latched, valid with out_valid;
  - out_err resets to 0 and clears on handshake.
- Undefined: in_exp and out_err ports absent. Behaviour otherwise identical.

## Structure
- Package parity_pkg holds:
  - state enum {IDLE, ACCUM, HOLD};
  - MODE_EVEN = 1'b0 and MODE_ODD = 1'b1;
  - a function for count width.
- Sub-module parity_reduce (WIDTH param, combinational XOR reduction of one word), instantiated NCH times by generate loop.

## Test plan
- WIDTH=8, NCH=2, MAXLEN=4, mode=0, single beat ch0=0x07, ch1=0x03, in_last=1 -> next cycle out_valid=1, out_parity=2'b01, out_len=1, out_trunc=0.
- mode=1, 3 beats ch0=0x01 each, ch1=0x00 each, last on beat 3 -> out_parity=2'b10, out_len=3, out_trunc=0.
- 4 beats, in_last never asserted -> out_valid after beat 4, out_len=4, out_trunc=1, in_ready=0 until handshake.
- Result held with out_ready=0 for 5 cycles while in_valid=1 -> out_* stable, in_ready=0, no beat accepted; out_ready=1 -> IDLE next cycle, new beat accepted the cycle after.
- Assert rst_n low after 2 accepted beats -> all outputs 0, state IDLE; a following 1-beat frame ch0=0x01, ch1=0x00, mode 0 -> out_parity=2'b01, out_len=1.
- PARITY_CHECK_EN: frame of one beat ch0=0x01, ch1=0x01, in_exp=2'b01 -> out_err=2'b10.

Source files
------------

// File: rtl/parity_frame_accum_pkg.sv
// Shared types for the frame parity accumulator: FSM states, parity-sense
// encodings and the frame-length counter width helper.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  function automatic int cnt_width(input int maxlen);
    return $clog2(maxlen + 1);
  endfunction

endpackage

// File: rtl/parity_frame_accum_if.sv
// Beat-in / result-out bundle for parity_frame_accum; in_exp/out_err only
// exist when PARITY_CHECK_EN is defined.
interface parity_frame_accum_if
  import parity_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 2,
  parameter int MAXLEN = 16
) ();

  localparam int CW = cnt_width(MAXLEN);

  logic                  in_valid;
  logic                  in_ready;
  logic [NCH*WIDTH-1:0]  in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [NCH-1:0]        out_parity;
  logic [CW-1:0]         out_len;
  logic                  out_trunc;
`ifdef PARITY_CHECK_EN
  logic [NCH-1:0]        in_exp;
  logic [NCH-1:0]        out_err;

  modport master (
    output in_valid, in_data, in_last, in_exp, out_ready,
    input  in_ready, out_valid, out_parity, out_len, out_trunc, out_err
  );
  modport slave (
    input  in_valid, in_data, in_last, in_exp, out_ready,
    output in_ready, out_valid, out_parity, out_len, out_trunc, out_err
  );
`else
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_parity, out_len, out_trunc
  );
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_parity, out_len, out_trunc
  );
`endif

endinterface

// File: rtl/parity_frame_accum_reduce.sv
// Single-word XOR reduction; purely combinational, no latency, no handshake.
module parity_reduce #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] word,
  output logic             par
);

  assign par = ^word;

endmodule

// File: rtl/parity_frame_accum.sv
// Per-channel frame parity accumulator; result registered 1 cycle after the closing beat.
// in_ready drops while a result is held or E is low; optional PARITY_CHECK_EN adds in_exp/out_err.
module parity_frame_accum
  import parity_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NCH    = 2,
  parameter int MAXLEN = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 E,
  input  logic                 mode,
  parity_frame_accum_if.slave  bus
);

  localparam int             CW      = cnt_width(MAXLEN);
  localparam logic [CW-1:0]  LEN_MAX = CW'(MAXLEN);

  state_t          state, state_n;
  logic [NCH-1:0]  word_par;
  logic [NCH-1:0]  acc, acc_nxt;
  logic [NCH-1:0]  par_q;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic            mode_q, mode_eff;
  logic            trunc;
  logic            accept, close, take;
`ifdef PARITY_CHECK_EN
  logic [NCH-1:0]  err_q;
`endif

  for (genvar c = 0; c < NCH; c++) begin : g_reduce
    parity_reduce #(.WIDTH(WIDTH)) u_reduce (
      .word (bus.in_data[c*WIDTH +: WIDTH]),
      .par  (word_par[c])
    );
  end

  assign bus.in_ready = E && (state != HOLD);
  assign accept       = bus.in_valid && bus.in_ready;
  assign take         = (state == HOLD) && bus.out_ready;

  // First beat of a frame restarts the accumulator and takes the live mode.
  always_comb begin
    acc_nxt  = acc ^ word_par;
    cnt_nxt  = cnt + CW'(1);
    mode_eff = mode_q;
    if (state == IDLE) begin
      acc_nxt  = word_par;
      cnt_nxt  = CW'(1);
      mode_eff = mode;
    end
    close = accept && (bus.in_last || (cnt_nxt == LEN_MAX));
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, ACCUM: begin
        if (close)       state_n = HOLD;
        else if (accept) state_n = ACCUM;
      end
      HOLD:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      cnt    <= '0;
      mode_q <= MODE_EVEN;
      trunc  <= 1'b0;
      par_q  <= '0;
`ifdef PARITY_CHECK_EN
      err_q  <= '0;
`endif
    end else if (take) begin
      acc    <= '0;
      cnt    <= '0;
      trunc  <= 1'b0;
      par_q  <= '0;
`ifdef PARITY_CHECK_EN
      err_q  <= '0;
`endif
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        cnt <= cnt_nxt;
        if (state == IDLE) mode_q <= mode;
      end
      if (close) begin
        par_q <= acc_nxt ^ {NCH{mode_eff}};
        trunc <= !bus.in_last;
`ifdef PARITY_CHECK_EN
        err_q <= acc_nxt ^ {NCH{mode_eff}} ^ bus.in_exp;
`endif
      end
    end
  end

  assign bus.out_valid  = (state == HOLD);
  assign bus.out_parity = par_q;
  assign bus.out_len    = cnt;
  assign bus.out_trunc  = trunc;
`ifdef PARITY_CHECK_EN
  assign bus.out_err    = err_q;
`endif

endmodule

// File: tb/tb_parity_frame_accum.sv
// Bench for parity_frame_accum (WIDTH=8, NCH=2, MAXLEN=4): table vectors,
// hand-written hold/reset sequences and random frames against a ones-count model.
module tb_parity_frame_accum;
  import parity_pkg::*;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int ML = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic E     = 1'b0;
  logic mode  = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  parity_frame_accum_if #(.WIDTH(W), .NCH(N), .MAXLEN(ML)) bus ();

  parity_frame_accum #(.WIDTH(W), .NCH(N), .MAXLEN(ML)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .E     (E),
    .mode  (mode),
    .bus   (bus)
  );

  typedef struct packed {
    logic            m;
    logic [2:0]      n;
    logic [3:0][15:0] d;
    logic            last;
    logic [1:0]      exp;
    logic [1:0]      par;
    logic [2:0]      len;
    logic            tr;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Starts and ends at posedge+1; holds the beat until accepted.
  task automatic send(input logic [15:0] d, input logic last, input logic m,
                      input logic [1:0] e, input int gap);
    int t;
    t = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    mode         = m;
`ifdef PARITY_CHECK_EN
    bus.in_exp   = e;
`else
    if (e === 2'bxx) t = 0;
`endif
    if (gap > 0) begin
      E = 1'b0;
      for (int i = 0; i < gap; i++) begin
        @(negedge clk);
        chk("e_low_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      @(posedge clk); #1;
      E = 1'b1;
    end
    @(negedge clk);
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic get_result(input string nm, input logic [1:0] par, input int len,
                            input logic tr, input logic [1:0] err, input int hold);
    int t;
    t = 0;
    @(negedge clk);
    chk({nm, " latency"}, {31'd0, bus.out_valid}, 32'd1);
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({nm, " parity"}, {30'd0, bus.out_parity}, {30'd0, par});
    chk({nm, " len"},    {29'd0, bus.out_len}, len);
    chk({nm, " trunc"},  {31'd0, bus.out_trunc}, {31'd0, tr});
    chk({nm, " ready_in_hold"}, {31'd0, bus.in_ready}, 32'd0);
`ifdef PARITY_CHECK_EN
    chk({nm, " err"}, {30'd0, bus.out_err}, {30'd0, err});
`else
    if (err === 2'bxx) t = 0;
`endif
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, " hold"}, {28'd0, bus.out_valid, bus.out_parity, bus.in_ready},
          {28'd0, 1'b1, par, 1'b0});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk({nm, " clear"}, {27'd0, bus.out_valid, bus.out_len, bus.out_trunc}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [1:0] par_m;
    logic [1:0] exp_m;
    logic [15:0] d;
    int ones[N];
    int L;
    logic tr, m;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
`ifdef PARITY_CHECK_EN
    bus.in_exp    = '0;
`endif

    // {m, n, beats (beat0 in low slot), last, exp, parity, len, trunc}
    vecs[0] = '{1'b0, 3'd1, {16'h0000, 16'h0000, 16'h0000, 16'h0307}, 1'b1, 2'b00, 2'b01, 3'd1, 1'b0};
    vecs[1] = '{1'b1, 3'd3, {16'h0000, 16'h0001, 16'h0001, 16'h0001}, 1'b1, 2'b00, 2'b10, 3'd3, 1'b0};
    vecs[2] = '{1'b0, 3'd4, {16'h0000, 16'hFF01, 16'h0300, 16'h0101}, 1'b0, 2'b11, 2'b10, 3'd4, 1'b1};
    vecs[3] = '{1'b1, 3'd4, {16'h0000, 16'h0000, 16'h0000, 16'h8001}, 1'b1, 2'b10, 2'b00, 3'd4, 1'b0};
    vecs[4] = '{1'b0, 3'd2, {16'h0000, 16'h0000, 16'h0100, 16'hFFFF}, 1'b1, 2'b00, 2'b10, 3'd2, 1'b0};
    vecs[5] = '{1'b0, 3'd1, {16'h0000, 16'h0000, 16'h0000, 16'h0101}, 1'b1, 2'b01, 2'b11, 3'd1, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {26'd0, bus.out_valid, bus.out_parity, bus.out_len},
        32'd0);
    chk("reset trunc", {31'd0, bus.out_trunc}, 32'd0);
    rst_n = 1'b1;
    E     = 1'b1;
    @(posedge clk); #1;
    chk("idle ready", {31'd0, bus.in_ready}, 32'd1);

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < int'(vecs[v].n); b++)
        send(vecs[v].d[b], vecs[v].last && (b == int'(vecs[v].n) - 1),
             (b == 0) ? vecs[v].m : ~vecs[v].m, vecs[v].exp, 0);
      get_result($sformatf("vec%0d", v), vecs[v].par, int'(vecs[v].len), vecs[v].tr,
                 vecs[v].par ^ vecs[v].exp, 1);
    end

    // Held result under backpressure while a new beat is already offered.
    send(16'h0001, 1'b1, 1'b0, 2'b00, 0);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h0300;
    bus.in_last  = 1'b1;
    mode         = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold stable", {26'd0, bus.out_valid, bus.out_parity, bus.in_ready, bus.out_len},
          {26'd0, 1'b1, 2'b01, 1'b0, 3'd1});
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("hold release", {30'd0, bus.out_valid, bus.in_ready}, {30'd0, 1'b0, 1'b1});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    get_result("hold next", 2'b00, 1, 1'b0, 2'b00, 0);

    // Reset in the middle of an open frame.
    send(16'h0101, 1'b0, 1'b0, 2'b00, 0);
    send(16'h0101, 1'b0, 1'b0, 2'b00, 0);
    chk("pre-reset len", {29'd0, bus.out_len}, 32'd2);
    rst_n = 1'b0;
    #2;
    chk("midframe reset", {25'd0, bus.out_valid, bus.out_parity, bus.out_len, bus.out_trunc},
        32'd0);
    chk("reset idle ready", {31'd0, bus.in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'h0001, 1'b1, 1'b0, 2'b00, 0);
    get_result("after reset", 2'b01, 1, 1'b0, 2'b01, 0);

    // Random frames: parity = (total ones per channel mod 2) xor first-beat mode.
    for (int f = 0; f < 40; f++) begin
      L  = $urandom_range(1, ML);
      tr = (L == ML) && ($urandom_range(0, 1) == 1);
      m  = 1'($urandom_range(0, 1));
      exp_m = 2'b00;
      for (int c = 0; c < N; c++) ones[c] = 0;
      for (int b = 0; b < L; b++) begin
        d     = 16'($urandom);
        exp_m = 2'($urandom);
        for (int c = 0; c < N; c++) ones[c] += $countones(d[c*W +: W]);
        send(d, (b == L - 1) && !tr, (b == 0) ? m : 1'($urandom_range(0, 1)), exp_m,
             ($urandom_range(0, 3) == 0) ? 1 : 0);
      end
      for (int c = 0; c < N; c++) par_m[c] = 1'(ones[c] % 2) ^ m;
      get_result($sformatf("rand%0d", f), par_m, L, tr, par_m ^ exp_m,
                 $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
